// File: rtl/display_page_ctrl.sv
// Page selector for the 7-segment debug display: debounced page stepping over the
// 16-bit halves of four CPU taps, with a freeze switch that holds the shown word.
module display_page_ctrl #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned DEB_W      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_next,
  input  logic        freeze,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] alu_res,
  input  logic [31:0] mem_rdata,
  output logic [15:0] data_out,
  output logic [2:0]  page,
  output logic        frozen
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK_DN = 2'd1,
    HELD     = 2'd2,
    CHECK_UP = 2'd3
  } deb_state_t;

  logic             r_sync1;
  logic             r_btn_s;
  deb_state_t       r_state;
  deb_state_t       w_state_nxt;
  logic [DEB_W-1:0] r_cnt;
  logic [DEB_W-1:0] w_cnt_nxt;
  logic             w_step;
  logic [15:0]      w_sel;

  // Two-flop synchroniser for the raw button
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sync1 <= btn_next;
      r_btn_s <= r_sync1;
    end
  end

  // Debounce state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Debounce next-state; step fires only on the press-accept transition
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_btn_s) begin
          w_state_nxt = CHECK_DN;
          w_cnt_nxt   = '0;
        end
      end
      CHECK_DN: begin
        if (!r_btn_s) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_step      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DEB_W'(1);
        end
      end
      HELD: begin
        if (!r_btn_s) begin
          w_state_nxt = CHECK_UP;
          w_cnt_nxt   = '0;
        end
      end
      CHECK_UP: begin
        if (r_btn_s) begin
          w_state_nxt = HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + DEB_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Half-word select for the current page
  always_comb begin
    w_sel = 16'h0000;
    unique case (page)
      3'd0: w_sel = pc[15:0];
      3'd1: w_sel = pc[31:16];
      3'd2: w_sel = instr[15:0];
      3'd3: w_sel = instr[31:16];
      3'd4: w_sel = alu_res[15:0];
      3'd5: w_sel = alu_res[31:16];
      3'd6: w_sel = mem_rdata[15:0];
      3'd7: w_sel = mem_rdata[31:16];
      default: w_sel = 16'h0000;
    endcase
  end

  // Page keeps stepping while frozen; only the displayed word is held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      page     <= 3'd0;
      data_out <= 16'h0000;
      frozen   <= 1'b0;
    end else begin
      if (w_step) page <= page + 3'd1;
      if (!freeze) data_out <= w_sel;
      frozen <= freeze;
    end
  end

endmodule
